// File: rtl/mips_fetch_pkg.sv
// mips_fetch_pkg: shared fetch FSM state type and fetch constants
package mips_fetch_pkg;
  typedef enum logic [1:0] {IDLE, REQ, DONE, ERR} fetch_state_t;
  localparam logic [31:0] MIPS_NOP = 32'h0000_0000;
  localparam int INSTR_BYTES = 4;
endpackage

// File: rtl/fetch_timeout_ctr.sv
// fetch_timeout_ctr: counts REQ cycles without ack and flags the final allowed cycle
// Ports: clk, rst_n (async active-low), clr (restart count), expire (count == TIMEOUT-1)
module fetch_timeout_ctr #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic expire
);
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else cnt <= clr ? '0 : cnt + CW'(1);
  assign expire = cnt == CW'(TIMEOUT - 1);
endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: PC-driven instruction fetch over a registered req/ack handshake
// Ports: clk, rst_n (async active-low), pc in; imem_req/imem_addr out, imem_ack/imem_data in;
//   instr, instr_valid, stall, pc_plus4, fetch_err out.
// Optional: define FETCH_TIMEOUT_EN to abort a request after TIMEOUT un-acked REQ cycles.
module instr_fetch_unit
  import mips_fetch_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] pc,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [DATA_W-1:0] imem_data,
  output logic [DATA_W-1:0] instr,
  output logic              instr_valid,
  output logic              stall,
  output logic [ADDR_W-1:0] pc_plus4,
  output logic              fetch_err
);
  fetch_state_t state, nxt;
  logic addr_ld, instr_ld, expire;
  logic aligned, chg;
  assign aligned = pc[1:0] == 2'b00;
  assign chg     = pc != imem_addr;
`ifdef FETCH_TIMEOUT_EN
  fetch_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_ctr (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (state != REQ || imem_ack),
    .expire (expire)
  );
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
  assign expire = 1'b0;
`endif
  always_comb begin
    nxt      = state;
    addr_ld  = 1'b0;
    instr_ld = 1'b0;
    case (state)
      IDLE: begin
        nxt     = aligned ? REQ : ERR;
        addr_ld = 1'b1;
      end
      REQ:
        if (imem_ack) begin
          // ack for a stale address is dropped and the new pc is requested
          nxt      = !chg ? DONE : aligned ? REQ : ERR;
          instr_ld = !chg;
          addr_ld  = chg;
        end else if (expire) nxt = ERR;
      DONE:
        if (chg) begin
          nxt     = aligned ? REQ : ERR;
          addr_ld = 1'b1;
        end
      ERR:
        if (chg && aligned) begin
          nxt     = REQ;
          addr_ld = 1'b1;
        end
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state     <= IDLE;
      imem_addr <= '0;
      instr     <= DATA_W'(MIPS_NOP);
    end else begin
      state <= nxt;
      if (addr_ld) imem_addr <= pc;
      if (instr_ld) instr <= imem_data;
    end
  assign imem_req    = state == REQ;
  assign instr_valid = state == DONE;
  assign stall       = state != DONE;
  assign fetch_err   = state == ERR;
  assign pc_plus4    = imem_addr + ADDR_W'(INSTR_BYTES);
endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Instruction-fetch front end that consumes the program counter and reads the addressed word from instruction memory over a registered req/ack handshake. It sits between the PC register and the decode stage. It holds the fetched instruction stable for decode, provides PcPlus4 to the next-PC logic, and raises Stall while a fetch is outstanding so the PC register does not advance.

## Interface
- ADDR_W, 32, width of Pc and ImemAddr
- DATA_W, 32, instruction word width
- TIMEOUT, 15, REQ cycles without ack before a fetch error (used only with the timeout feature)
- Clk  in  1  clock; all state updates on the rising edge
- Rst  in  1  asynchronous, active-low reset
- Pc  in  ADDR_W  current program counter from the PC register
- ImemReq  out  1  fetch request to instruction memory
- ImemAddr  out  ADDR_W  fetch address; stable while ImemReq=1
- ImemAck  in  1  memory acknowledge; ImemData is valid in the same cycle
- ImemData  in  DATA_W  instruction word from memory
- Instr  out  DATA_W  last successfully fetched instruction
- InstrValid  out  1  Instr corresponds to the current Pc
- Stall  out  1  fetch not complete; the PC must hold
- PcPlus4  out  ADDR_W  ImemAddr + 4, modulo 2^ADDR_W
- FetchErr  out  1  misaligned Pc, or fetch timeout

## Operation
- FSM states: IDLE, REQ, DONE, ERR.
- IDLE:
  - Entered only from reset.
  - On the next edge: if Pc[1:0]≠0, go to ERR; otherwise go to REQ and set ImemAddr←Pc.
- REQ:
  - ImemReq=1 and ImemAddr is held.
  - On an edge with ImemAck=1 and Pc==ImemAddr: Instr←ImemData, go to DONE.
  - On an edge with ImemAck=1 and Pc≠ImemAddr: discard the data and leave Instr unchanged. If the new Pc is aligned, stay in REQ with ImemAddr←Pc; otherwise go to ERR.
- DONE:
  - When Pc≠ImemAddr: aligned Pc goes to REQ with ImemAddr←Pc; misaligned Pc goes to ERR.
  - Otherwise stay in DONE.
- ERR:
  - FetchErr=1 and ImemReq=0.
  - Exit when Pc≠ImemAddr and Pc is aligned: go to REQ with ImemAddr←Pc.
  - On a misaligned entry, ImemAddr←Pc so that the exit compare works.
- ImemAck outside REQ is ignored.
- Output decode:
  - InstrValid = (state==DONE)
  - Stall = (state≠DONE)
  - ImemReq = (state==REQ)
  - FetchErr = (state==ERR)
  - All four are decoded from registered state only.
- PcPlus4 is combinational from ImemAddr. 0xFFFFFFFC wraps to 0x00000000.
- Reset values: state IDLE, ImemReq 0, ImemAddr 0, Instr 0x00000000 (MIPS NOP), InstrValid 0, Stall 1, PcPlus4 4, FetchErr 0.
- Reset asserted mid-fetch aborts the request immediately (asynchronous). The outstanding ack is not tracked after reset.

## Timing
- Pc is sampled at edge k (from IDLE or DONE). ImemReq rises after edge k.
- Earliest completion: ack during cycle k+1, so Instr and InstrValid update after edge k+1. Minimum latency is 2 edges from the Pc change; Stall is high for exactly 1 cycle.
- Each cycle of ack delay adds one cycle of Stall.
- ImemAddr never changes while ImemReq=1 unless ack is sampled in the same edge.

## Configuration
- FETCH_TIMEOUT_EN defined:
  - A cycle counter clears on entry to REQ and increments each REQ cycle without ack.
  - On the edge where count==TIMEOUT-1 and ImemAck=0, go to ERR; ImemReq drops after that edge.
  - Ack on that same edge takes priority.
- FETCH_TIMEOUT_EN undefined:
  - No counter; REQ waits indefinitely.
  - FetchErr indicates misalignment only.
  - TIMEOUT is unused.

## Structure
- Package mips_fetch_pkg holds:
  - the fetch_state_t enum (IDLE, REQ, DONE, ERR)
  - MIPS_NOP = 32'h00000000
  - INSTR_BYTES = 4
- Sub-module fetch_timeout_ctr contains the counter and the expiry compare. It is instantiated only under FETCH_TIMEOUT_EN.

## Test plan
- Release reset with Pc=0x00000000 and ack one cycle after req → ImemAddr=0; Instr=ImemData=0x2008000A; InstrValid=1; PcPlus4=4; Stall high for 1 cycle.
- Step Pc 0→4→8 with ack delayed 3 cycles each → Stall high 3 cycles per fetch; ImemAddr stable throughout each request; Instr tracks each word.
- Change Pc from 0x10 to 0x20 while REQ for 0x10 is pending; ack 0x10 data → that data is discarded and Instr is unchanged; a new REQ goes out with ImemAddr=0x20; only the 0x20 data reaches Instr.
- Pc=0x00000006 → ERR, FetchErr=1, ImemReq=0. Then Pc=0x00000008 → REQ and a normal fetch.
- With FETCH_TIMEOUT_EN and TIMEOUT=15, never ack → ImemReq low after the 15th REQ cycle and FetchErr=1. Without the macro → ImemReq stays high for over 100 cycles.
- Pc=0xFFFFFFFC fetch completes → PcPlus4=0x00000000. Assert Rst mid-REQ → all outputs return to their reset values immediately.
